// File: rtl/sd_image_responder_if.sv
// Bus bundle between the sector requester / image memory (master side)
// and the sd_image_responder (slave side).
interface sd_image_responder_if #(
  parameter int IMG_AW = 20
);
  // Handshakes: sd_rd/sd_wr are level requests answered by sd_ack, which stays
  // high for the whole block and whose falling edge means done. mem_rd/mem_wr
  // are level requests held until a one-cycle mem_ready pulse; mem_dout is
  // valid only with mem_ready. sd_buff_wr is a one-cycle strobe qualifying
  // sd_buff_addr/sd_buff_dout in the same cycle.
  logic [31:0]     sd_lba;
  logic            sd_rd;
  logic            sd_wr;
  logic            sd_ack;
  logic [8:0]      sd_buff_addr;
  logic [7:0]      sd_buff_dout;
  logic [7:0]      sd_buff_din;
  logic            sd_buff_wr;
  logic [IMG_AW:0] img_size;
  logic            img_readonly;
  logic [IMG_AW-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [7:0]      mem_din;
  logic [7:0]      mem_dout;
  logic            mem_ready;
  logic            range_err;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, img_readonly,
           mem_dout, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
           mem_rd, mem_wr, mem_din, range_err
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, img_readonly,
           mem_dout, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
           mem_rd, mem_wr, mem_din, range_err
  );
endinterface

// File: rtl/sd_image_responder.sv
// Serves 512-byte sector reads/writes from a disk image held in an external
// byte-wide memory, one byte per memory handshake.
module sd_image_responder #(
  parameter int IMG_AW = 20
) (
  input  logic               clk,
  input  logic               reset,
  sd_image_responder_if.slave bus,
  output logic [2:0]         dbg_state
);
  typedef enum logic [2:0] {
    IDLE, RD_FETCH, RD_PUT, WR_SET, WR_W1, WR_LATCH, WR_STORE, DONE
  } state_t;

  state_t      state;
  logic [31:0] lba;
  logic [9:0]  cnt;
  logic [9:0]  cnt_nx;
  logic [40:0] ba_cur;
  logic [40:0] ba_nx;
  logic [40:0] ba_acc;
  logic        cur_ok;
  logic        nx_ok;
  logic        acc_ok;

  function automatic logic [40:0] byte_addr(input logic [31:0] l, input logic [8:0] i);
    return {l, 9'd0} + {32'd0, i};
  endfunction

  function automatic logic in_range(input logic [40:0] a, input logic [IMG_AW:0] sz);
    return a < {{(40-IMG_AW){1'b0}}, sz};
  endfunction

  // Addresses for the current byte, the next byte and the first byte of a new
  // request, so strobes can rise on the same edge that enters the access state.
  always_comb begin
    cnt_nx = cnt + 10'd1;
    ba_cur = byte_addr(lba, cnt[8:0]);
    ba_nx  = byte_addr(lba, cnt_nx[8:0]);
    ba_acc = byte_addr(bus.sd_lba, 9'd0);
    cur_ok = in_range(ba_cur, bus.img_size);
    nx_ok  = in_range(ba_nx, bus.img_size);
    acc_ok = in_range(ba_acc, bus.img_size);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      lba              <= 32'd0;
      cnt              <= 10'd0;
      bus.sd_ack       <= 1'b0;
      bus.sd_buff_wr   <= 1'b0;
      bus.sd_buff_addr <= 9'd0;
      bus.sd_buff_dout <= 8'd0;
      bus.mem_rd       <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_din      <= 8'd0;
      bus.mem_addr     <= '0;
      bus.range_err    <= 1'b0;
    end else begin
      bus.sd_buff_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sd_rd || bus.sd_wr) begin
            lba           <= bus.sd_lba;
            cnt           <= 10'd0;
            bus.sd_ack    <= 1'b1;
            bus.range_err <= 1'b0;
          end
          if (bus.sd_rd) begin
            state        <= RD_FETCH;
            bus.mem_rd   <= acc_ok;
            bus.mem_addr <= ba_acc[IMG_AW-1:0];
          end else if (bus.sd_wr) begin
            state            <= WR_SET;
            bus.sd_buff_addr <= 9'd0;
          end
        end

        // mem_rd low here means the byte was out of range at entry.
        RD_FETCH: begin
          if (!bus.mem_rd || bus.mem_ready) begin
            bus.sd_buff_dout <= bus.mem_rd ? bus.mem_dout : 8'h00;
            if (!bus.mem_rd) bus.range_err <= 1'b1;
            bus.mem_rd       <= 1'b0;
            bus.sd_buff_addr <= cnt[8:0];
            bus.sd_buff_wr   <= 1'b1;
            state            <= RD_PUT;
          end
        end

        RD_PUT: begin
          cnt <= cnt_nx;
          if (cnt == 10'd511) begin
            state      <= DONE;
            bus.sd_ack <= 1'b0;
          end else begin
            state        <= RD_FETCH;
            bus.mem_rd   <= nx_ok;
            bus.mem_addr <= ba_nx[IMG_AW-1:0];
          end
        end

        WR_SET: state <= WR_W1;

        WR_W1: state <= WR_LATCH;

        WR_LATCH: begin
          bus.mem_din  <= bus.sd_buff_din;
          bus.mem_addr <= ba_cur[IMG_AW-1:0];
          bus.mem_wr   <= cur_ok && !bus.img_readonly;
          state        <= WR_STORE;
        end

        // A skipped access (out of range or readonly) still takes one cycle.
        WR_STORE: begin
          if (!bus.mem_wr && !cur_ok) bus.range_err <= 1'b1;
          if (!bus.mem_wr || bus.mem_ready) begin
            bus.mem_wr <= 1'b0;
            cnt        <= cnt_nx;
            if (cnt == 10'd511) begin
              state      <= DONE;
              bus.sd_ack <= 1'b0;
            end else begin
              state            <= WR_SET;
              bus.sd_buff_addr <= cnt_nx[8:0];
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_image_responder.sv
// Randomized bench for sd_image_responder: requester buffer and image memory
// models, a sector-level reference model feeding expected queues, and monitors.
module tb_sd_image_responder;
  localparam int IMG_AW = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  sd_image_responder_if #(.IMG_AW(IMG_AW)) bus ();

  sd_image_responder #(.IMG_AW(IMG_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem  [0:(1<<IMG_AW)-1];
  logic [7:0]  wbuf [0:511];
  logic [16:0] exp_q[$];
  logic [27:0] wexp_q[$];
  int checks = 0;
  int errors = 0;
  int ack_cycles = 0;
  int strobes = 0;
  int rd_hs = 0;
  int mem_k = 1;
  bit stale_pulse = 1'b0;
  bit overlap = 1'b0;

  task automatic finish_report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester's synchronous buffer RAM: data follows the address by one clock.
  initial begin
    logic [8:0] a;
    bus.sd_buff_din = 8'h00;
    forever begin
      @(posedge clk);
      a = bus.sd_buff_addr;
      #1;
      bus.sd_buff_din = wbuf[a];
    end
  end

  // Image memory: answers a held request mem_k cycles after it is first seen.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_dout  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_dout  = 8'($urandom);
      if (reset) begin
        wcnt = 0;
      end else if (bus.mem_rd || bus.mem_wr) begin
        wcnt++;
        if (wcnt >= mem_k) begin
          wcnt = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_rd) bus.mem_dout = mem[bus.mem_addr];
          else mem[bus.mem_addr] = bus.mem_din;
        end
      end else begin
        wcnt = 0;
      end
      if (stale_pulse) begin
        bus.mem_ready = 1'b1;
        stale_pulse = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [27:0] we;
    if (bus.sd_ack) ack_cycles++;
    if (bus.mem_rd && bus.mem_wr) overlap = 1'b1;
    if (bus.mem_rd && bus.mem_ready) rd_hs++;
    if (bus.sd_buff_wr) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL buff_strobe: unexpected strobe addr %0d data %0h", bus.sd_buff_addr, bus.sd_buff_dout);
      end else begin
        e = exp_q.pop_front();
        if ({bus.sd_buff_addr, bus.sd_buff_dout} !== e) begin
          errors++;
          $display("FAIL buff_strobe: got addr %0d data %0h expected addr %0d data %0h",
                   bus.sd_buff_addr, bus.sd_buff_dout, e[16:8], e[7:0]);
        end
      end
    end
    if (bus.mem_wr && bus.mem_ready) begin
      checks++;
      if (wexp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write: unexpected write addr %0h data %0h", bus.mem_addr, bus.mem_din);
      end else begin
        we = wexp_q.pop_front();
        if ({bus.mem_addr, bus.mem_din} !== we) begin
          errors++;
          $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.mem_addr, bus.mem_din, we[27:8], we[7:0]);
        end
      end
    end
  end

  task automatic wait_ack(input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sd_ack !== v && n < 20000);
    if (bus.sd_ack !== v) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: sd_ack is %b, wanted %b", bus.sd_ack, v);
      finish_report();
    end
  endtask

  // Expected sector image: bytes below img_size come from memory, others read 0.
  task automatic do_read(input logic [31:0] lba, input int k, input bit both, input bit b2b);
    logic [40:0] a;
    int exp_cycles, exp_rd, w;
    bit exp_err;
    exp_cycles = 0; exp_rd = 0; exp_err = 1'b0;
    mem_k = k;
    for (int i = 0; i < 512; i++) begin
      a = {lba, 9'd0} + 41'(i);
      if (a < 41'(bus.img_size)) begin
        exp_q.push_back({9'(i), mem[a[19:0]]});
        exp_cycles += k + 1;
        exp_rd++;
      end else begin
        exp_q.push_back({9'(i), 8'h00});
        exp_cycles += 2;
        exp_err = 1'b1;
      end
    end
    if (!b2b) repeat (3) @(negedge clk);
    ack_cycles = 0; strobes = 0; rd_hs = 0;
    bus.sd_lba = lba;
    bus.sd_rd  = 1'b1;
    bus.sd_wr  = both;
    wait_ack(1'b1, w);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    if (b2b) check("b2b_gap", 64'(w), 64'(2));
    wait_ack(1'b0, w);
    check("rd_ack_cycles", 64'(ack_cycles), 64'(exp_cycles));
    check("rd_range_err", 64'(bus.range_err), 64'(exp_err));
    check("rd_leftover", 64'(exp_q.size()), 64'(0));
    check("rd_mem_reads", 64'(rd_hs), 64'(exp_rd));
  endtask

  task automatic do_write(input logic [31:0] lba, input int k, input bit ro, input bit rnd);
    logic [40:0] a;
    logic [7:0]  snap [0:511];
    logic [7:0]  want;
    int exp_cycles, w, bad;
    bit exp_err;
    exp_cycles = 0; bad = 0; exp_err = 1'b0;
    mem_k = k;
    bus.img_readonly = ro;
    for (int i = 0; i < 512; i++) begin
      wbuf[i] = rnd ? 8'($urandom) : (8'hA5 ^ 8'(i));
      a = {lba, 9'd0} + 41'(i);
      snap[i] = mem[a[19:0]];
      if (a >= 41'(bus.img_size)) begin
        exp_cycles += 4;
        exp_err = 1'b1;
      end else if (ro) begin
        exp_cycles += 4;
      end else begin
        wexp_q.push_back({a[19:0], wbuf[i]});
        exp_cycles += k + 3;
      end
    end
    repeat (3) @(negedge clk);
    ack_cycles = 0; strobes = 0;
    bus.sd_lba = lba;
    bus.sd_wr  = 1'b1;
    wait_ack(1'b1, w);
    bus.sd_wr = 1'b0;
    wait_ack(1'b0, w);
    check("wr_ack_cycles", 64'(ack_cycles), 64'(exp_cycles));
    check("wr_range_err", 64'(bus.range_err), 64'(exp_err));
    check("wr_leftover", 64'(wexp_q.size()), 64'(0));
    check("wr_no_strobe", 64'(strobes), 64'(0));
    for (int i = 0; i < 512; i++) begin
      a = {lba, 9'd0} + 41'(i);
      want = (a < 41'(bus.img_size) && !ro) ? wbuf[i] : snap[i];
      if (mem[a[19:0]] !== want) bad++;
    end
    check("wr_mem_image", 64'(bad), 64'(0));
    bus.img_readonly = 1'b0;
  endtask

  task automatic reset_mid_read();
    logic [40:0] a;
    int w, cyc;
    mem_k = 2;
    for (int i = 0; i < 512; i++) begin
      a = {32'd4, 9'd0} + 41'(i);
      exp_q.push_back({9'(i), mem[a[19:0]]});
    end
    repeat (3) @(negedge clk);
    strobes = 0;
    bus.sd_lba = 32'd4;
    bus.sd_rd  = 1'b1;
    wait_ack(1'b1, w);
    bus.sd_rd = 1'b0;
    cyc = 0;
    while (strobes < 200 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_byte200", 64'(strobes >= 200), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ack", 64'(bus.sd_ack), 64'(0));
    check("rst_mid_mem_rd", 64'(bus.mem_rd), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    stale_pulse = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stale_idle", 64'({bus.sd_ack, bus.sd_buff_wr}), 64'(0));
    do_read(32'd0, 1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] lba;
    int k;
    for (int a = 0; a < (1 << IMG_AW); a++) mem[a] = 8'(a) ^ 8'(a >> 8);
    for (int i = 0; i < 512; i++) wbuf[i] = 8'h00;
    reset = 1'b1;
    bus.sd_lba = 32'd0;
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    bus.img_size = 21'd174848;
    bus.img_readonly = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({bus.sd_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr, bus.range_err}), 64'(0));
    check("rst_addr", 64'({bus.sd_buff_addr, bus.mem_addr}), 64'(0));
    check("rst_data", 64'({bus.sd_buff_dout, bus.mem_din}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;

    do_read(32'd3, 1, 1'b0, 1'b0);
    do_write(32'd5, 3, 1'b0, 1'b0);
    do_read(32'd5, 1, 1'b0, 1'b0);

    bus.img_size = 21'd1000;
    do_read(32'd1, 2, 1'b0, 1'b0);
    do_read(32'd2, 1, 1'b0, 1'b0);
    bus.img_size = 21'd174848;

    do_write(32'd0, 2, 1'b1, 1'b1);
    do_read(32'd7, 1, 1'b1, 1'b0);
    reset_mid_read();
    do_read(32'd6, 1, 1'b0, 1'b0);
    do_read(32'd9, 2, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      bus.img_size = 21'($urandom_range(700, 5000));
      lba = 32'($urandom_range(0, 9));
      k = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) do_read(lba, k, 1'b0, 1'b0);
      else do_write(lba, k, $urandom_range(0, 3) == 0, 1'b1);
    end

    check("rd_wr_overlap", 64'(overlap), 64'(0));
    finish_report();
  end
endmodule

// File: doc/sd_image_responder.md
# sd_image_responder

Target-side block-transfer engine that services 512-byte sector requests from the 1541 track loader (`sd_rd`/`sd_wr`/`sd_ack` handshake with a byte-wide buffer port). It stands in for the IO controller in simulation and in standalone builds. It serves sectors from a disk image (D64/G64) held in an external byte-wide memory, typically SDRAM. Reads stream image bytes into the requester's buffer; writes pull bytes out of it and store them back.

## Interface
- `IMG_AW`, 20: image byte-address width; max image 2^IMG_AW bytes.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `sd_lba`  in  32  sector number; sampled at request acceptance
- `sd_rd`  in  1  read request (level)
- `sd_wr`  in  1  write request (level)
- `sd_ack`  out  1  high for the entire transfer; its falling edge means block done
- `sd_buff_addr`  out  9  byte index within sector
- `sd_buff_dout`  out  8  read data to requester
- `sd_buff_din`  in  8  write data from requester; its synchronous RAM shows the byte 1 clk after the address
- `sd_buff_wr`  out  1  one-cycle strobe; `sd_buff_dout`/`sd_buff_addr` valid in the same cycle
- `img_size`  in  IMG_AW+1  image length in bytes
- `img_readonly`  in  1  discard writes, but still complete the handshake
- `mem_addr`  out  IMG_AW  byte address
- `mem_rd`, `mem_wr`  out  1  level requests, held until `mem_ready`
- `mem_din`  out  8  write data to memory
- `mem_dout`  in  8  read data, valid with `mem_ready`
- `mem_ready`  in  1  one-cycle completion pulse
- `range_err`  out  1  sticky; set when any byte of the current transfer is at or beyond `img_size`; cleared at the next acceptance

## Operation
- States: IDLE, RD_FETCH, RD_PUT, WR_SET, WR_W1, WR_LATCH, WR_STORE, DONE.
- IDLE: if `sd_rd`, accept a read. Otherwise, if `sd_wr`, accept a write. If both are high, the read wins and the write is not latched.
- Acceptance does the following: latch `sd_lba`; `cnt`(10b)=0; `sd_ack`=1; clear `range_err`.
  - Read: go to RD_FETCH.
  - Write: go to WR_SET.
- Byte address: `ba` = {lba, 9'b0} + cnt[8:0], computed at 41 bits. In range means `ba` < `img_size` (zero-extended). `mem_addr` = `ba`[IMG_AW-1:0].
- RD_FETCH:
  - In range: hold `mem_rd`=1 until `mem_ready`, then register `mem_dout` into `sd_buff_dout` and drop `mem_rd`.
  - Out of range: no memory access, `sd_buff_dout`=8'h00, `range_err`=1.
  - Then go to RD_PUT.
- RD_PUT: `sd_buff_addr`=cnt[8:0], `sd_buff_wr`=1 for this cycle only. `cnt`++. If `cnt` was 511, go to DONE; otherwise go to RD_FETCH.
- WR_SET: drive `sd_buff_addr`=cnt[8:0], then go to WR_W1 and then WR_LATCH. The address is stable for 2 edges before sampling.
- WR_LATCH: `mem_din` <= `sd_buff_din`.
- WR_STORE: write to memory only when in range and `!img_readonly`. In that case hold `mem_wr`=1 until `mem_ready`.
  - Out of range: skip the access and set `range_err`.
  - Readonly: skip the access silently.
  - Then `cnt`++. If `cnt` was 511, go to DONE; otherwise go to WR_SET.
- DONE: `sd_ack`=0 and go to IDLE. Requests are not sampled in DONE, so the minimum gap between transfers is 1 idle cycle.
- `sd_buff_wr` is never asserted during a write transfer.
- `mem_rd` and `mem_wr` are never high together, and are never high outside RD_FETCH/WR_STORE.

## Timing
- Reset values:
  - `sd_ack`, `sd_buff_wr`, `mem_rd`, `mem_wr`, `range_err` = 0.
  - `sd_buff_addr`, `sd_buff_dout`, `mem_din`, `mem_addr` = 0.
  - State = IDLE.
- Reset mid-transfer aborts the transfer immediately: `sd_ack` drops on the next edge. A `mem_ready` that arrives after reset is ignored.
- Acceptance: the request is seen high in IDLE at edge N; `sd_ack` is high after N.
- For `mem_ready` arriving k≥1 cycles after the strobe rises:
  - Read byte = k+1 cycles; read block = 512·(k+1) cycles of `sd_ack` high.
  - Write byte = k+3 cycles; write block = 512·(k+3) cycles.
- Out-of-range or readonly bytes use k=1 timing, i.e. the skipped access takes one cycle.
- `sd_buff_addr` increments monotonically 0..511 with no gaps or repeats. `range_err` may set mid-block.
- A request held high through DONE is re-accepted in IDLE as a new transfer. The requester is responsible for dropping its request on seeing `sd_ack`.

## Test plan
- Read: `img_size`=174848, memory holds byte = addr[7:0] ^ addr[15:8]. Read LBA 3 with k=1 → 512 `sd_buff_wr` strobes, addr 0..511, data (0x600+i) pattern; `sd_ack` high for 1024 cycles; `range_err`=0.
- Write: LBA 5, requester buffer = 0xA5 ^ i, k=3 → memory bytes 0xA00..0xBFF match; no `sd_buff_wr`; `sd_ack` high for 3072 cycles.
- Boundaries:
  - `img_size`=1000, read LBA 1 → bytes 512..999 from memory, bytes 488..511 of the sector = 0x00, `range_err`=1.
  - Read LBA 2 → all 0x00, no `mem_rd` ever asserted.
- Readonly: `img_readonly`=1, write LBA 0 → `mem_wr` never asserted, handshake completes normally, memory unchanged.
- Priority and reset:
  - `sd_rd` and `sd_wr` rise together → read performed.
  - Assert `reset` at byte 200 of a read → `sd_ack`=0 next cycle, `mem_rd`=0; a new read of LBA 0 afterwards completes correctly despite a stale `mem_ready`.
- Back-to-back: the requester raises `sd_rd` on the cycle after `sd_ack` falls → accepted after exactly one IDLE cycle, with data correct for the new LBA.
